jk_drive_encoder: RTL and testbench

- Transmit-side encoder for banks of JK flip-flops with clear.
- Accepts a queue of target state vectors and converts each one into the per-bit J/K pair that moves the downstream flops to that target on the next clock edge.
- Keeps a shadow model of the downstream Q vector so it can choose hold, set, clear or toggle.
- Sits between sequencing logic and the gate-level flop banks, so upstream logic deals in states instead of J/K encodings.

---
 rtl/jk_drive_encoder.sv | 91 +++++++++
 tb/tb_jk_drive_encoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/jk_drive_encoder.sv
// Target-state FIFO that emits per-lane J/K pairs, so the downstream JK flops reach each popped target.
// A shadow copy of the downstream Q is used to choose hold/set/clear/toggle per lane.
module jk_drive_encoder #(
    parameter int WIDTH         = 4,
    parameter int DEPTH         = 4,
    parameter bit PREFER_TOGGLE = 1'b0
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       adv,
    input  logic                       flop_clr,
    output logic [WIDTH-1:0]           j,
    output logic [WIDTH-1:0]           k,
    output logic [WIDTH-1:0]           q_model,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] q_reg;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign in_ready = ~full & ~r;
    assign push     = in_valid & in_ready;
    // Reset also masks pop so the flops see hold while the encoder is being cleared.
    assign pop      = adv & ~empty & ~r;
    assign head     = mem[rd_ptr_reg];

    assign count   = count_reg;
    assign q_model = q_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic set_bit;
            logic clr_bit;
            assign set_bit = head[gi] & ~q_reg[gi];
            assign clr_bit = ~head[gi] & q_reg[gi];
            assign j[gi]   = pop & (set_bit | (PREFER_TOGGLE & clr_bit));
            assign k[gi]   = pop & (clr_bit | (PREFER_TOGGLE & set_bit));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk) begin
        if (r) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            q_reg      <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (flop_clr) begin
                q_reg <= '0;
            end else if (pop) begin
                q_reg <= head;
            end
        end
    end

endmodule

// File: tb/tb_jk_drive_encoder.sv
// Directed, table-driven check of jk_drive_encoder; a toggle-preferring copy shares the stimulus.
module tb_jk_drive_encoder;

    logic       clk = 1'b0;
    logic       r;
    logic [3:0] in_data;
    logic       in_valid;
    logic       adv;
    logic       flop_clr;

    logic       in_ready, empty, full;
    logic [3:0] j, k, q_model;
    logic [2:0] count;

    logic       t_in_ready, t_empty, t_full;
    logic [3:0] t_j, t_k, t_q_model;
    logic [2:0] t_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_drive_encoder #(.WIDTH(4), .DEPTH(4), .PREFER_TOGGLE(1'b0)) dut (
        .clk(clk), .r(r), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .adv(adv), .flop_clr(flop_clr), .j(j), .k(k), .q_model(q_model),
        .empty(empty), .full(full), .count(count)
    );

    jk_drive_encoder #(.WIDTH(4), .DEPTH(4), .PREFER_TOGGLE(1'b1)) dut_t (
        .clk(clk), .r(r), .in_data(in_data), .in_valid(in_valid), .in_ready(t_in_ready),
        .adv(adv), .flop_clr(flop_clr), .j(t_j), .k(t_k), .q_model(t_q_model),
        .empty(t_empty), .full(t_full), .count(t_count)
    );

    typedef struct {
        logic       r, vld, adv, clr;
        logic [3:0] din;
        logic [3:0] ej, ek, eq;
        logic [2:0] ecnt;
        logic       eempty, efull, erdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rr, vld, a, c, input logic [3:0] din,
                       input logic [3:0] ej, ek, eq, input logic [2:0] ecnt,
                       input logic ee, ef, erdy);
        vec_t v;
        v.r = rr; v.vld = vld; v.adv = a; v.clr = c; v.din = din;
        v.ej = ej; v.ek = ek; v.eq = eq; v.ecnt = ecnt;
        v.eempty = ee; v.efull = ef; v.erdy = erdy;
        vecs.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input logic rr, vld, a, c, input logic [3:0] din);
        r = rr; in_valid = vld; adv = a; flop_clr = c; in_data = din;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // r vld adv clr din    | j     k     q     cnt e f rdy
        add(1,0,0,0,4'b0000, 4'b0000,4'b0000,4'b0000,3'd0,1,0,0); // 0 reset state
        add(0,1,0,0,4'b1010, 4'b0000,4'b0000,4'b0000,3'd0,1,0,1); // 1 push 1010
        add(0,0,1,0,4'b0000, 4'b1010,4'b0000,4'b0000,3'd1,0,0,1); // 2 pop 1010
        add(0,1,0,0,4'b0110, 4'b0000,4'b0000,4'b1010,3'd0,1,0,1); // 3 push 0110
        add(0,0,1,0,4'b0000, 4'b0100,4'b1000,4'b1010,3'd1,0,0,1); // 4 pop 0110
        add(0,1,0,0,4'b0001, 4'b0000,4'b0000,4'b0110,3'd0,1,0,1); // 5 fill
        add(0,1,0,0,4'b0010, 4'b0000,4'b0000,4'b0110,3'd1,0,0,1); // 6
        add(0,1,0,0,4'b0100, 4'b0000,4'b0000,4'b0110,3'd2,0,0,1); // 7
        add(0,1,0,0,4'b1000, 4'b0000,4'b0000,4'b0110,3'd3,0,0,1); // 8
        add(0,1,0,0,4'b1111, 4'b0000,4'b0000,4'b0110,3'd4,0,1,0); // 9 fifth push refused
        add(0,0,1,0,4'b0000, 4'b0001,4'b0110,4'b0110,3'd4,0,1,0); // 10 drain
        add(0,0,1,0,4'b0000, 4'b0010,4'b0001,4'b0001,3'd3,0,0,1); // 11
        add(0,0,1,0,4'b0000, 4'b0100,4'b0010,4'b0010,3'd2,0,0,1); // 12
        add(0,0,1,0,4'b0000, 4'b1000,4'b0100,4'b0100,3'd1,0,0,1); // 13
        add(0,1,0,0,4'b0011, 4'b0000,4'b0000,4'b1000,3'd0,1,0,1); // 14 push after wrap
        add(0,1,0,0,4'b1100, 4'b0000,4'b0000,4'b1000,3'd1,0,0,1); // 15
        add(0,1,1,0,4'b0101, 4'b0011,4'b1000,4'b1000,3'd2,0,0,1); // 16 push+pop at 2
        add(0,0,1,0,4'b0000, 4'b1100,4'b0011,4'b0011,3'd2,0,0,1); // 17
        add(0,0,1,0,4'b0000, 4'b0001,4'b1000,4'b1100,3'd1,0,0,1); // 18
        add(0,1,1,0,4'b1111, 4'b0000,4'b0000,4'b0101,3'd0,1,0,1); // 19 push into empty + adv
        add(0,0,1,1,4'b0000, 4'b1010,4'b0000,4'b0101,3'd1,0,0,1); // 20 clr over pop
        add(0,1,0,0,4'b1111, 4'b0000,4'b0000,4'b0000,3'd0,1,0,1); // 21
        add(0,0,1,1,4'b0000, 4'b1111,4'b0000,4'b0000,3'd1,0,0,1); // 22 clr with pop 1111
        add(0,1,0,0,4'b0101, 4'b0000,4'b0000,4'b0000,3'd0,1,0,1); // 23
        add(0,0,1,0,4'b0000, 4'b0101,4'b0000,4'b0000,3'd1,0,0,1); // 24
        add(0,1,0,0,4'b0001, 4'b0000,4'b0000,4'b0101,3'd0,1,0,1); // 25
        add(0,1,0,0,4'b0010, 4'b0000,4'b0000,4'b0101,3'd1,0,0,1); // 26
        add(0,1,0,0,4'b0100, 4'b0000,4'b0000,4'b0101,3'd2,0,0,1); // 27
        add(1,0,1,0,4'b0000, 4'b0000,4'b0000,4'b0101,3'd3,0,0,0); // 28 reset beats adv
        add(0,0,1,0,4'b0000, 4'b0000,4'b0000,4'b0000,3'd0,1,0,1); // 29 adv while empty

        drive(1, 0, 0, 0, 4'b0000);
        next_cycle();
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].vld, vecs[i].adv, vecs[i].clr, vecs[i].din);
            #2;
            chk(i, "j",        32'(j),        32'(vecs[i].ej));
            chk(i, "k",        32'(k),        32'(vecs[i].ek));
            chk(i, "t_j",      32'(t_j),      32'(vecs[i].ej | vecs[i].ek));
            chk(i, "t_k",      32'(t_k),      32'(vecs[i].ej | vecs[i].ek));
            chk(i, "q_model",  32'(q_model),  32'(vecs[i].eq));
            chk(i, "t_q",      32'(t_q_model), 32'(vecs[i].eq));
            chk(i, "count",    32'(count),    32'(vecs[i].ecnt));
            chk(i, "empty",    32'(empty),    32'(vecs[i].eempty));
            chk(i, "full",     32'(full),     32'(vecs[i].efull));
            chk(i, "in_ready", 32'(in_ready), 32'(vecs[i].erdy));
            $display("step %0d: r=%b vld=%b adv=%b clr=%b din=%b -> j=%b k=%b q=%b cnt=%0d",
                     i, vecs[i].r, vecs[i].vld, vecs[i].adv, vecs[i].clr, vecs[i].din,
                     j, k, q_model, count);
            next_cycle();
        end

        // Push attempted during reset is not accepted.
        drive(1, 1, 0, 0, 4'b1001);
        #2;
        chk(100, "rst_ready", 32'(in_ready), 32'(0));
        next_cycle();
        drive(0, 0, 0, 0, 4'b0000);
        #2;
        chk(101, "rst_push_cnt", 32'(count), 32'(0));
        $display("seq rst_push: count=%0d empty=%b", count, empty);
        next_cycle();

        // Two entries queued, then reset mid-stream discards both.
        drive(0, 1, 0, 0, 4'b1001);
        next_cycle();
        drive(0, 1, 0, 0, 4'b0110);
        next_cycle();
        drive(0, 0, 0, 0, 4'b0000);
        #2;
        chk(102, "mid_cnt", 32'(count), 32'(2));
        next_cycle();
        drive(1, 0, 1, 0, 4'b0000);
        #2;
        chk(103, "mid_rst_j", 32'(j), 32'(0));
        next_cycle();
        drive(0, 0, 1, 0, 4'b0000);
        #2;
        chk(104, "mid_cnt0", 32'(count), 32'(0));
        chk(105, "mid_empty", 32'(empty), 32'(1));
        chk(106, "mid_j", 32'(j), 32'(0));
        $display("seq mid_reset: count=%0d empty=%b j=%b", count, empty, j);
        next_cycle();

        // After the discard, a fresh entry pops with q_model=0000 as the reference.
        drive(0, 1, 0, 0, 4'b0011);
        next_cycle();
        drive(0, 0, 1, 0, 4'b0000);
        #2;
        chk(107, "fresh_j", 32'(j), 32'(4'b0011));
        chk(108, "fresh_k", 32'(k), 32'(4'b0000));
        next_cycle();
        drive(0, 0, 0, 0, 4'b0000);
        #2;
        chk(109, "fresh_q", 32'(q_model), 32'(4'b0011));
        $display("seq fresh: q=%b count=%0d", q_model, count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
